// File: rtl/systolic_pkg.sv
// Shared constants and FSM encoding for the systolic array drain path.
// Default array size and word width live here.
package systolic_pkg;

    localparam int SYS_N       = 4;
    localparam int SYS_W       = 32;
    localparam int FRAME_BEATS = SYS_N * SYS_N;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        STREAM  = 2'd2
    } drain_state_t;

endpackage

// File: rtl/result_buffer_nxn.sv
// NxN word store: one full row written per cycle, one word read
// combinationally. Contents are intentionally not reset.
module result_buffer_nxn #(
    parameter int N = 4,
    parameter int W = 32
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [$clog2(N)-1:0] wrow_i,
    input  logic [N*W-1:0]       wdata_i,
    input  logic [$clog2(N)-1:0] rrow_i,
    input  logic [$clog2(N)-1:0] rcol_i,
    output logic [W-1:0]         rdata_o
);

    logic [W-1:0] mem_q [N][N];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int c = 0; c < N; c++) begin
                mem_q[wrow_i][c] <= wdata_i[c*W +: W];
            end
        end
    end

    assign rdata_o = mem_q[rrow_i][rcol_i];

endmodule

// File: rtl/systolic_drain_collector.sv
// Captures the column-parallel drain of the systolic array and replays it
// row-major on AXI4-Stream. Define DRAIN_RELU_EN to clamp negatives at capture.
module systolic_drain_collector
    import systolic_pkg::*;
#(
    parameter int N = SYS_N,
    parameter int W = SYS_W
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_col_valid,
    input  logic [N*W-1:0] i_col_data,
    output logic           o_busy,
    output logic           o_overflow,
    output logic [W-1:0]   m_axis_tdata,
    output logic           m_axis_tvalid,
    input  logic           m_axis_tready,
    output logic           m_axis_tlast
);

    localparam int KW    = $clog2(N);
    localparam int BW    = $clog2(N*N);
    localparam int BEATS = N * N;

    drain_state_t state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [BW-1:0] b_q, b_d, b_nxt;
    logic [W-1:0]  tdata_q, tdata_d;
    logic          tvalid_q, tvalid_d;
    logic          tlast_q, tlast_d;
    logic          busy_q, busy_d;
    logic          ovf_q, ovf_d;

    logic           we;
    logic [KW-1:0]  wr_row, rd_row, rd_col;
    logic [N*W-1:0] cap_data;
    logic [W-1:0]   rd_data;

    always_comb begin
        cap_data = i_col_data;
`ifdef DRAIN_RELU_EN
        for (int c = 0; c < N; c++) begin
            if (i_col_data[c*W + W - 1]) cap_data[c*W +: W] = '0;
        end
`endif
    end

    // Bottom row drains first, so capture k lands in row N-1-k.
    assign wr_row = KW'(N - 1) - k_q;
    assign b_nxt  = b_q + 1'b1;
    assign rd_row = KW'(b_nxt / BW'(N));
    assign rd_col = KW'(b_nxt % BW'(N));

    result_buffer_nxn #(.N(N), .W(W)) u_buf (
        .clk_i   (i_clk),
        .we_i    (we),
        .wrow_i  (wr_row),
        .wdata_i (cap_data),
        .rrow_i  (rd_row),
        .rcol_i  (rd_col),
        .rdata_o (rd_data)
    );

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        b_d      = b_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        busy_d   = busy_q;
        ovf_d    = ovf_q;
        we       = 1'b0;
        unique case (state_q)
            IDLE, CAPTURE: begin
                if (i_col_valid) begin
                    we     = 1'b1;
                    busy_d = 1'b1;
                    if (k_q == KW'(N - 1)) begin
                        // Row 0 is being written now; forward beat 0 directly.
                        k_d      = '0;
                        b_d      = '0;
                        state_d  = STREAM;
                        tvalid_d = 1'b1;
                        tlast_d  = 1'b0;
                        tdata_d  = cap_data[W-1:0];
                    end else begin
                        k_d     = k_q + 1'b1;
                        state_d = CAPTURE;
                    end
                end
            end
            STREAM: begin
                if (i_col_valid) ovf_d = 1'b1;
                if (tvalid_q && m_axis_tready) begin
                    if (b_q == BW'(BEATS - 1)) begin
                        state_d  = IDLE;
                        b_d      = '0;
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        busy_d   = 1'b0;
                    end else begin
                        b_d     = b_nxt;
                        tdata_d = rd_data;
                        tlast_d = (b_nxt == BW'(BEATS - 1));
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q  <= IDLE;
            k_q      <= '0;
            b_q      <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            b_q      <= b_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            busy_q   <= busy_d;
            ovf_q    <= ovf_d;
        end
    end

    assign o_busy        = busy_q;
    assign o_overflow    = ovf_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;

endmodule

// File: tb/tb_systolic_drain_collector.sv
// Randomised self-checking bench for systolic_drain_collector against a
// row-major replay model of the drained columns.
module tb_systolic_drain_collector;
    import systolic_pkg::*;

    localparam int N = SYS_N;
    localparam int W = SYS_W;
    localparam int NB = N * N;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           col_valid = 1'b0;
    logic [N*W-1:0] col_data = '0;
    logic           busy, ovf, tvalid, tready = 1'b0, tlast;
    logic [W-1:0]   tdata;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] words [N][N];
    logic [W-1:0] exp_d [NB];
    logic [W-1:0] got_d [NB];
    logic         got_l [NB];
    int           got_n, stall_bad;
    logic         timeout, rst_hit, ovf_before, ovf_next;

    always #5 clk = ~clk;

    systolic_drain_collector #(.N(N), .W(W)) dut (
        .i_clk         (clk),
        .i_rst         (rst_n),
        .i_col_valid   (col_valid),
        .i_col_data    (col_data),
        .o_busy        (busy),
        .o_overflow    (ovf),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tlast  (tlast)
    );

    function automatic logic [W-1:0] relu(input logic [W-1:0] x);
`ifdef DRAIN_RELU_EN
        return x[W-1] ? '0 : x;
`else
        return x;
`endif
    endfunction

    // Drain cycle k carries row N-1-k; the stream is plain row-major order.
    task automatic build_expected();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                exp_d[r*N + c] = relu(words[N-1-r][c]);
    endtask

    task automatic set_basic();
        for (int k = 0; k < N; k++)
            for (int c = 0; c < N; c++)
                words[k][c] = W'(N*(N-1-k) + c);
    endtask

    task automatic set_random();
        for (int k = 0; k < N; k++)
            for (int c = 0; c < N; c++)
                words[k][c] = W'($urandom);
    endtask

    task automatic drive_frame(input int gap_at, input int gap_len);
        for (int k = 0; k < N; k++) begin
            if (k == gap_at) begin
                col_valid = 1'b0;
                repeat (gap_len) begin
                    @(posedge clk); #1;
                end
            end
            col_valid = 1'b1;
            for (int c = 0; c < N; c++) col_data[c*W +: W] = words[k][c];
            @(posedge clk); #1;
        end
        col_valid = 1'b0;
        col_data = '0;
    endtask

    // Records accepted beats; bp: 0 always ready, 1 pattern 1,0,0,1, 2 random.
    task automatic collect(input int bp, input int ovf_at, input int rst_at);
        int cyc;
        logic held, pulsed, sampled, rdy;
        logic [W-1:0] hd;
        logic hl;
        got_n = 0; stall_bad = 0; cyc = 0; held = 0;
        pulsed = 0; sampled = 0; rst_hit = 0;
        ovf_before = 0; ovf_next = 0; hd = '0; hl = 0;
        while (got_n < NB && cyc < 400) begin
            if (pulsed && !sampled) begin
                ovf_next = ovf;
                sampled = 1;
            end
            if (held && !(tvalid === 1'b1 && tdata === hd && tlast === hl))
                stall_bad++;
            if (rst_at == got_n && tvalid === 1'b1) begin
                rst_hit = 1;
                break;
            end
            case (bp)
                0: rdy = 1'b1;
                1: rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            tready = rdy;
            col_valid = 1'b0;
            if (ovf_at == got_n && !pulsed && tvalid === 1'b1) begin
                col_valid = 1'b1;
                col_data = {N{32'hDEAD_BEEF}};
                ovf_before = ovf;
                pulsed = 1;
            end
            if (tvalid === 1'b1 && rdy) begin
                got_d[got_n] = tdata;
                got_l[got_n] = tlast;
                got_n++;
                held = 0;
            end else begin
                held = (tvalid === 1'b1);
                hd = tdata;
                hl = tlast;
            end
            @(posedge clk); #1;
            cyc++;
        end
        col_valid = 1'b0;
        col_data = '0;
        timeout = (got_n < NB) && !rst_hit;
    endtask

    task automatic check_frame(input string tag);
        checks++;
        if (timeout !== 1'b0 || got_n != NB) begin
            errors++;
            $display("FAIL %s beats: got %0d want %0d", tag, got_n, NB);
        end
        checks++;
        if (stall_bad != 0) begin
            errors++;
            $display("FAIL %s stall_stable: got %0d changes want 0", tag, stall_bad);
        end
        for (int i = 0; i < got_n; i++) begin
            checks++;
            if (got_d[i] !== exp_d[i]) begin
                errors++;
                $display("FAIL %s tdata[%0d]: got %h want %h", tag, i, got_d[i], exp_d[i]);
            end
            checks++;
            if (got_l[i] !== (i == NB - 1)) begin
                errors++;
                $display("FAIL %s tlast[%0d]: got %b want %b", tag, i, got_l[i], i == NB - 1);
            end
        end
        checks++;
        if ({tvalid, tlast, busy} !== 3'b000) begin
            errors++;
            $display("FAIL %s idle_after: got tvalid/tlast/busy %b want 000", tag, {tvalid, tlast, busy});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, ovf, tvalid, tlast} !== 4'b0 || tdata !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %b/%h want 0000/0", {busy, ovf, tvalid, tlast}, tdata);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        set_basic();
        build_expected();
        col_valid = 1'b1;
        for (int c = 0; c < N; c++) col_data[c*W +: W] = words[0][c];
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_before: got %b want 0", busy);
        end
        drive_frame(-1, 0);
        checks++;
        if (tvalid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL first_beat_latency: got tvalid %b busy %b want 1 1", tvalid, busy);
        end
        collect(0, -1, -1);
        check_frame("basic");
    endtask

    task automatic test_gapped();
        set_basic();
        build_expected();
        drive_frame(2, 3);
        collect(0, -1, -1);
        check_frame("gapped");
    endtask

    task automatic test_backpressure();
        set_basic();
        build_expected();
        drive_frame(-1, 0);
        collect(1, -1, -1);
        check_frame("backpressure");
    endtask

    task automatic test_relu();
        set_random();
        words[0][1] = 32'hFFFF_FFF6;
        words[2][3] = 32'h8000_0000;
        build_expected();
        drive_frame(-1, 0);
        collect(0, -1, -1);
        check_frame("relu");
        checks++;
`ifdef DRAIN_RELU_EN
        if (got_d[N*(N-1) + 1] !== 32'h0) begin
`else
        if (got_d[N*(N-1) + 1] !== 32'hFFFF_FFF6) begin
`endif
            errors++;
            $display("FAIL relu_neg10: got %h", got_d[N*(N-1) + 1]);
        end
    endtask

    task automatic test_overflow();
        set_basic();
        build_expected();
        drive_frame(-1, 0);
        collect(0, 5, -1);
        check_frame("overflow");
        checks++;
        if (ovf_before !== 1'b0 || ovf_next !== 1'b1) begin
            errors++;
            $display("FAIL overflow_flag: got before %b after %b want 0 1", ovf_before, ovf_next);
        end
    endtask

    task automatic test_last_beat_collision();
        set_basic();
        build_expected();
        drive_frame(-1, 0);
        collect(0, NB - 1, -1);
        check_frame("collision");
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("FAIL collision_overflow: got %b want 1", ovf);
        end
        set_random();
        build_expected();
        drive_frame(-1, 0);
        collect(0, -1, -1);
        check_frame("after_collision");
    endtask

    task automatic test_reset_mid_stream();
        set_random();
        build_expected();
        drive_frame(-1, 0);
        collect(0, -1, 7);
        rst_n = 1'b0;
        #1;
        checks++;
        if (rst_hit !== 1'b1 || {tvalid, tlast, busy, ovf} !== 4'b0) begin
            errors++;
            $display("FAIL reset_mid_stream: got hit %b outs %b want 1 0000",
                     rst_hit, {tvalid, tlast, busy, ovf});
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        set_basic();
        build_expected();
        drive_frame(-1, 0);
        collect(0, -1, -1);
        check_frame("post_reset");
    endtask

    task automatic test_random();
        for (int f = 0; f < 4; f++) begin
            set_random();
            build_expected();
            drive_frame(int'($urandom_range(0, N)), int'($urandom_range(1, 4)));
            collect(2, -1, -1);
            check_frame("random");
            checks++;
            if (ovf !== 1'b0) begin
                errors++;
                $display("FAIL random_overflow: got %b want 0", ovf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gapped();
        test_backpressure();
        test_relu();
        test_overflow();
        test_last_beat_collision();
        test_reset_mid_stream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
